// File: rtl/gpr_wport_arbiter_if.sv
// Signal bundle between the GPR write-port arbiter and its neighbours:
// writeback (port A), long-latency unit (port B), GPR write inputs and hazard/stall outputs.
interface gpr_wport_arbiter_if;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_reg;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        gpr_we;
    logic [4:0]  gpr_wreg;
    logic [31:0] gpr_wdata;
    logic [31:0] pend_mask;
    logic        stall_req;

    modport master (
        output wb_we, wb_reg, wb_data, lu_valid, lu_reg, lu_data,
        input  lu_ready, gpr_we, gpr_wreg, gpr_wdata, pend_mask, stall_req
    );

    modport slave (
        input  wb_we, wb_reg, wb_data, lu_valid, lu_reg, lu_data,
        output lu_ready, gpr_we, gpr_wreg, gpr_wdata, pend_mask, stall_req
    );
endinterface

// File: rtl/gpr_wport_arbiter.sv
// Single GPR write port shared by writeback (port A, always wins) and a queued
// long-latency port B, with younger-write squashing, pending mask and starvation stall.
module gpr_wport_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    gpr_wport_arbiter_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [4:0]    r_reg  [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic          r_lu_ready;
    logic          r_gpr_we;
    logic [4:0]    r_gpr_wreg;
    logic [31:0]   r_gpr_wdata;
    logic          r_stall_req;

    logic          w_a_req;
    logic          w_hs;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_head_live;
    logic [CW-1:0] w_count_next;
    logic [SW-1:0] w_starve_next;
    logic [DEPTH-1:0] w_live_next;
    logic [31:0]   w_pend;

    // Port B handshake: a transfer happens on an edge where lu_valid && lu_ready;
    // lu_ready is registered, so it only reflects occupancy as of the previous edge.
    assign w_a_req     = bus.wb_we && (bus.wb_reg != 5'd0);
    assign w_hs        = bus.lu_valid && r_lu_ready;
    assign w_push      = w_hs && (bus.lu_reg != 5'd0);
    assign w_empty     = (r_count == '0);
    assign w_head_live = !w_empty && r_live[r_rptr];
    assign w_pop       = !w_a_req && !w_empty;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    // Live bits only exist for occupied slots, so pend_mask never sees stale entries.
    always_comb begin
        w_live_next = r_live;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_a_req && (r_reg[i] == bus.wb_reg))
                w_live_next[i] = 1'b0;
        end
        if (w_pop)
            w_live_next[r_rptr] = 1'b0;
        if (w_push)
            w_live_next[r_wptr] = !(w_a_req && (bus.lu_reg == bus.wb_reg));
    end

    always_comb begin
        w_starve_next = '0;
        if (w_head_live && w_a_req)
            w_starve_next = (r_starve == LIMIT_C) ? r_starve : r_starve + SW'(1);
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i])
                w_pend[r_reg[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_reg[i]  <= '0;
                r_data[i] <= '0;
            end
            r_live      <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_starve    <= '0;
            r_lu_ready  <= 1'b0;
            r_gpr_we    <= 1'b0;
            r_gpr_wreg  <= '0;
            r_gpr_wdata <= '0;
            r_stall_req <= 1'b0;
        end else begin
            if (w_push) begin
                r_reg[r_wptr]  <= bus.lu_reg;
                r_data[r_wptr] <= bus.lu_data;
                r_wptr         <= r_wptr + AW'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            r_live      <= w_live_next;
            r_count     <= w_count_next;
            r_starve    <= w_starve_next;
            r_lu_ready  <= (w_count_next < DEPTH_C);
            r_stall_req <= (w_starve_next == LIMIT_C);

            if (w_a_req) begin
                r_gpr_we    <= 1'b1;
                r_gpr_wreg  <= bus.wb_reg;
                r_gpr_wdata <= bus.wb_data;
            end else if (w_head_live) begin
                r_gpr_we    <= 1'b1;
                r_gpr_wreg  <= r_reg[r_rptr];
                r_gpr_wdata <= r_data[r_rptr];
            end else begin
                r_gpr_we    <= 1'b0;
            end
        end
    end

    assign bus.lu_ready  = r_lu_ready;
    assign bus.gpr_we    = r_gpr_we;
    assign bus.gpr_wreg  = r_gpr_wreg;
    assign bus.gpr_wdata = r_gpr_wdata;
    assign bus.pend_mask = w_pend;
    assign bus.stall_req = r_stall_req;
endmodule
